// File: rtl/multicycle_control_unit_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit_if
//   Bundle between the multicycle RV64I control unit and its datapath.
//   The master side is the control unit: it reads the decoded instruction
//   fields and the branch flag, and it drives every datapath strobe and mux
//   select. The slave side is the datapath.
//
//   Signals (direction as seen from the master):
//     opcode     in   7  instr[6:0] from the instruction register
//     funct3     in   3  instr[14:12] from the instruction register
//     zero_flag  in   1  output of the branch-flag one_bit_register
//     pc_load    out  1  PC register load
//     ir_load    out  1  instruction register / old-PC register load
//     rf_load    out  1  register-file write enable
//     flag_load  out  1  branch-flag register load
//     mem_read   out  1  memory read
//     mem_write  out  1  data memory write
//     alu_src    out  1  0 = rs2, 1 = immediate
//     alu_op     out  2  00 add, 01 sub, 10 decode from funct fields
//     pc_src     out  2  00 PC+4, 01 old_pc+imm, 10 jal target
//     wb_sel     out  2  00 ALU, 01 memory data, 10 old_pc+4
//     halted     out  1  high while the unit is halted
//
//   Handshake: there is no valid/ready pair. Every strobe is a one-cycle
//   (or fixed-length) level sampled by the datapath on the rising clock
//   edge; memory has a fixed latency, so no ready signal comes back.
// ----------------------------------------------------------------------------
interface multicycle_control_unit_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero_flag;
    logic       pc_load;
    logic       ir_load;
    logic       rf_load;
    logic       flag_load;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] wb_sel;
    logic       halted;

    modport master (
        input  opcode, funct3, zero_flag,
        output pc_load, ir_load, rf_load, flag_load, mem_read, mem_write,
               alu_src, alu_op, pc_src, wb_sel, halted
    );

    modport slave (
        output opcode, funct3, zero_flag,
        input  pc_load, ir_load, rf_load, flag_load, mem_read, mem_write,
               alu_src, alu_op, pc_src, wb_sel, halted
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
//   Moore FSM sequencing the multicycle RV64I datapath through FETCH, DECODE,
//   EXEC, MEM, WB and BRANCH, with a terminal HALT for unknown opcodes.
//
//   Parameters:
//     MEM_WAIT     extra wait cycles per memory access (0..7)
//
//   Ports:
//     clk          in   clock, all state updates on posedge
//     reset        in   synchronous active-high; forces FETCH, clears counter
//     bus          master modport of multicycle_control_unit_if
//     dbg_state_o  out  current state encoding (0 while reset is high)
//
//   The instruction class and funct3 are captured in DECODE so later states
//   do not depend on the instruction register staying stable.
// ----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_control_unit_if.master     bus,
    output logic [2:0]                    dbg_state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_HALT   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_R      = 3'd0,
        C_I      = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4,
        C_JAL    = 3'd5
    } cls_e;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_e     state_q, state_d;
    cls_e       cls_q, cls_d;
    logic [2:0] funct3_q, funct3_d;
    logic [2:0] cnt_q, cnt_d;

    logic       wait_done;
    logic       taken;

    logic       pc_load_c, ir_load_c, rf_load_c, flag_load_c;
    logic       mem_read_c, mem_write_c, alu_src_c, halted_c;
    logic [1:0] alu_op_c, pc_src_c, wb_sel_c;

    assign wait_done = (cnt_q == WAIT_LAST);

    // BEQ takes on equal (flag set), BNE on not-equal; other funct3 fall through.
    assign taken = ((funct3_q == 3'b000) &  bus.zero_flag) |
                   ((funct3_q == 3'b001) & ~bus.zero_flag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            cls_q    <= C_R;
            funct3_q <= 3'd0;
            cnt_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            funct3_q <= funct3_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        funct3_d    = funct3_q;
        cnt_d       = 3'd0;
        pc_load_c   = 1'b0;
        ir_load_c   = 1'b0;
        rf_load_c   = 1'b0;
        flag_load_c = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        alu_src_c   = 1'b0;
        alu_op_c    = 2'b00;
        pc_src_c    = 2'b00;
        wb_sel_c    = 2'b00;
        halted_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (wait_done) begin
                    ir_load_c = 1'b1;
                    pc_load_c = 1'b1;
                    state_d   = S_DECODE;
                end
            end

            S_DECODE: begin
                funct3_d = bus.funct3;
                state_d  = S_EXEC;
                case (bus.opcode)
                    7'b0110011: cls_d = C_R;
                    7'b0010011: cls_d = C_I;
                    7'b0000011: cls_d = C_LOAD;
                    7'b0100011: cls_d = C_STORE;
                    7'b1100011: cls_d = C_BRANCH;
                    7'b1101111: cls_d = C_JAL;
                    default:    state_d = S_HALT;
                endcase
            end

            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        alu_op_c = 2'b10;
                        state_d  = S_WB;
                    end
                    C_I: begin
                        alu_src_c = 1'b1;
                        alu_op_c  = 2'b10;
                        state_d   = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src_c = 1'b1;
                        state_d   = S_MEM;
                    end
                    C_BRANCH: begin
                        alu_op_c    = 2'b01;
                        flag_load_c = 1'b1;
                        state_d     = S_BRANCH;
                    end
                    C_JAL:   state_d = S_WB;
                    default: state_d = S_HALT;
                endcase
            end

            S_MEM: begin
                if (cls_q == C_LOAD) begin
                    mem_read_c = 1'b1;
                end else begin
                    mem_write_c = 1'b1;
                end
                if (wait_done) begin
                    state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
                end
            end

            S_WB: begin
                rf_load_c = 1'b1;
                state_d   = S_FETCH;
                if (cls_q == C_LOAD) begin
                    wb_sel_c = 2'b01;
                end else if (cls_q == C_JAL) begin
                    wb_sel_c  = 2'b10;
                    pc_load_c = 1'b1;
                    pc_src_c  = 2'b10;
                end
            end

            S_BRANCH: begin
                pc_src_c  = 2'b01;
                pc_load_c = taken;
                state_d   = S_FETCH;
            end

            S_HALT: begin
                halted_c = 1'b1;
            end

            default: state_d = S_FETCH;
        endcase

        // Counter only advances while waiting out a memory access; any
        // state change restarts it so the next wait starts from zero.
        if (state_d != state_q) begin
            cnt_d = 3'd0;
        end else if ((state_q == S_FETCH) || (state_q == S_MEM)) begin
            cnt_d = cnt_q + 3'd1;
        end

        // Reset suppresses every strobe in the very cycle it is seen, so an
        // aborted instruction leaves no partial write behind.
        if (reset) begin
            pc_load_c   = 1'b0;
            ir_load_c   = 1'b0;
            rf_load_c   = 1'b0;
            flag_load_c = 1'b0;
            mem_read_c  = 1'b0;
            mem_write_c = 1'b0;
            alu_src_c   = 1'b0;
            alu_op_c    = 2'b00;
            pc_src_c    = 2'b00;
            wb_sel_c    = 2'b00;
            halted_c    = 1'b0;
        end
    end

    assign bus.pc_load   = pc_load_c;
    assign bus.ir_load   = ir_load_c;
    assign bus.rf_load   = rf_load_c;
    assign bus.flag_load = flag_load_c;
    assign bus.mem_read  = mem_read_c;
    assign bus.mem_write = mem_write_c;
    assign bus.alu_src   = alu_src_c;
    assign bus.alu_op    = alu_op_c;
    assign bus.pc_src    = pc_src_c;
    assign bus.wb_sel    = wb_sel_c;
    assign bus.halted    = halted_c;

    assign dbg_state_o = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_unit
//   Directed and random instruction sequences. For every instruction the
//   bench builds the expected per-cycle output trace (state, strobes, selects)
//   from the instruction class, then compares the DUT cycle by cycle.
//   The branch-flag one_bit_register is modelled here and loaded with a
//   bench-chosen compare result whenever flag_load is high.
// ----------------------------------------------------------------------------
module tb_multicycle_control_unit;
  localparam int MW = 1;
  localparam int W  = 17;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [2:0] dbg_state;
  logic flag_q = 1'b0;
  logic cmp_val = 1'b0;
  int halt_len = 3;

  always #5 clk = ~clk;

  multicycle_control_unit_if u_if();

  multicycle_control_unit #(.MEM_WAIT(MW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (u_if),
    .dbg_state_o (dbg_state)
  );

  // branch-flag one_bit_register
  always @(posedge clk) begin
    if (u_if.flag_load) flag_q <= cmp_val;
  end
  assign u_if.zero_flag = flag_q;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  function automatic logic [W-1:0] obs_word();
    return {dbg_state, u_if.halted, u_if.pc_load, u_if.ir_load, u_if.rf_load,
            u_if.flag_load, u_if.mem_read, u_if.mem_write, u_if.alu_src,
            u_if.alu_op, u_if.pc_src, u_if.wb_sel};
  endfunction

  task automatic add(input logic [2:0] st, input logic hal, input logic pcl,
                     input logic irl, input logic rfl, input logic fll,
                     input logic mrd, input logic mwr, input logic asrc,
                     input logic [1:0] aop, input logic [1:0] psrc,
                     input logic [1:0] wsel);
    exp_q.push_back({st, hal, pcl, irl, rfl, fll, mrd, mwr, asrc, aop, psrc, wsel});
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected trace of one instruction, written from the instruction's
  // phase list: fetch (MW+1 cycles), decode, execute flavour, then the
  // class-specific tail.
  task automatic build(input logic [6:0] opc, input logic [2:0] f3, input logic cmp);
    logic tk;
    for (int i = 0; i <= MW; i++) begin
      add(3'd0, 0, (i == MW), (i == MW), 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00);
    end
    add(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    case (opc)
      OP_R: begin
        add(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00);
        add(3'd4, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      end
      OP_I: begin
        add(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
        add(3'd4, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      end
      OP_LD: begin
        add(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i <= MW; i++) add(3'd3, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00);
        add(3'd4, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01);
      end
      OP_ST: begin
        add(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i <= MW; i++) add(3'd3, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      end
      OP_BR: begin
        tk = ((f3 == 3'b000) && cmp) || ((f3 == 3'b001) && !cmp);
        add(3'd2, 0, 0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        add(3'd5, 0, tk, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
      end
      OP_JAL: begin
        add(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        add(3'd4, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10);
      end
      default: begin
        for (int i = 0; i < halt_len; i++) add(3'd7, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Entered 1 ns after a rising edge in the first FETCH cycle; limit=0 runs
  // the whole trace, otherwise only the first 'limit' cycles.
  task automatic run(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                     input logic cmp, input int limit);
    logic [W-1:0] e;
    int idx;
    exp_q.delete();
    build(opc, f3, cmp);
    cmp_val = cmp;
    idx = 0;
    while (exp_q.size() > 0 && (limit == 0 || idx < limit)) begin
      e = exp_q.pop_front();
      if (idx <= MW) begin
        u_if.opcode = 7'($urandom);
        u_if.funct3 = 3'($urandom);
      end else begin
        u_if.opcode = opc;
        u_if.funct3 = f3;
      end
      #1;
      check($sformatf("%s[%0d]", tag, idx), obs_word(), e);
      @(posedge clk);
      #1;
      idx++;
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      u_if.opcode = 7'($urandom);
      u_if.funct3 = 3'($urandom);
      #1;
      check("reset_zero", obs_word(), '0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [6:0] op_tab [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic cmp;
    op_tab[0] = OP_R;  op_tab[1] = OP_I;  op_tab[2] = OP_LD; op_tab[3] = OP_ST;
    op_tab[4] = OP_BR; op_tab[5] = OP_JAL; op_tab[6] = OP_BAD; op_tab[7] = 7'b0110010;

    reset = 1'b1;
    u_if.opcode = OP_R;
    u_if.funct3 = 3'd0;
    @(posedge clk);
    #1;

    apply_reset(3);
    run("r_type", OP_R, 3'b000, 1'b0, 0);
    run("load", OP_LD, 3'b011, 1'b0, 0);
    run("beq_taken", OP_BR, 3'b000, 1'b1, 0);
    run("beq_not", OP_BR, 3'b000, 1'b0, 0);
    run("bne_taken", OP_BR, 3'b001, 1'b0, 0);
    run("bne_not", OP_BR, 3'b001, 1'b1, 0);
    run("blt_never", OP_BR, 3'b100, 1'b1, 0);
    run("store", OP_ST, 3'b011, 1'b0, 0);
    run("i_alu", OP_I, 3'b000, 1'b0, 0);
    run("jal", OP_JAL, 3'b000, 1'b0, 0);

    halt_len = 20;
    run("halt", OP_BAD, 3'b000, 1'b0, 0);
    apply_reset(1);
    run("after_halt", OP_R, 3'b000, 1'b0, 0);

    // abort a STORE in its second MEM cycle: fetch, decode, exec, mem0 checked
    run("st_abort", OP_ST, 3'b011, 1'b0, MW + 4);
    apply_reset(1);
    run("after_abort", OP_LD, 3'b000, 1'b0, 0);

    halt_len = 3;
    for (int n = 0; n < 60; n++) begin
      opc = op_tab[$urandom_range(0, 7)];
      f3  = 3'($urandom_range(0, 7));
      cmp = 1'($urandom);
      run($sformatf("rnd%0d", n), opc, f3, cmp, 0);
      if (opc == OP_BAD || opc == 7'b0110010) apply_reset($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
